// File: rtl/mem_stage_access_unit.sv
// MEM stage of the pipeline: resolves the branch, runs the data-memory
// req/ack access with a timeout, raises the upstream stall and owns the
// MEM/WB pipeline register.
module mem_stage_access_unit #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] exe_mem_result,
    input  logic [31:0] exe_mem_store_data,
    input  logic [31:0] exe_mem_branch_address,
    input  logic [4:0]  exe_mem_dst_reg,
    input  logic        exe_mem_zero,
    input  logic        branch_equal_in,
    input  logic        branch_not_equal_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic [31:0] mem_wb_read_data,
    output logic [31:0] mem_wb_result,
    output logic [4:0]  mem_wb_dst_reg,
    output logic        mem_wb_mem_to_reg,
    output logic        mem_wb_reg_write,
    output logic        mem_misaligned,
    output logic        mem_timeout_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Last ACCESS cycle count before the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    logic memop;
    logic aligned;
    logic is_load;
    logic start_access;
    logic misaligned_op;
    logic pass_through;
    logic ack_done;
    logic timeout_hit;
    logic retire_access;

    assign memop         = mem_read_in | mem_write_in;
    assign aligned       = (exe_mem_result[1:0] == 2'b00);
    // A simultaneous read+write request is executed as a store.
    assign is_load       = mem_read_in & ~mem_write_in;
    assign start_access  = (state == IDLE) & memop & aligned;
    assign misaligned_op = (state == IDLE) & memop & ~aligned;
    assign pass_through  = (state == IDLE) & ~memop;
    assign ack_done      = (state == ACCESS) & dmem_ack;
    assign timeout_hit   = (state == ACCESS) & ~dmem_ack & (cnt == CNT_LAST);
    assign retire_access = ack_done | timeout_hit;

    // Stall is released in the completing cycle so upstream advances on the
    // same edge that writes MEM/WB.
    assign mem_stall = start_access
                     | ((state == ACCESS) & ~dmem_ack & (cnt != CNT_LAST));

    assign pc_src        = (branch_equal_in & exe_mem_zero)
                         | (branch_not_equal_in & ~exe_mem_zero);
    assign branch_target = exe_mem_branch_address;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: enter ACCESS on an aligned memory op, leave on ack or timeout.
    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (start_access) begin
                state_next = ACCESS;
            end
        end else begin
            if (retire_access) begin
                state_next = IDLE;
            end
        end
    end

    // Memory request registers and timeout counter; request fields stay frozen during ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            cnt        <= '0;
        end else if (start_access) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= exe_mem_result;
            dmem_wdata <= exe_mem_store_data;
            cnt        <= '0;
        end else if (retire_access) begin
            dmem_req <= 1'b0;
        end else if (state == ACCESS) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // MEM/WB register: pass-through, access completion, or bubble while the access is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_read_data  <= 32'd0;
            mem_wb_result     <= 32'd0;
            mem_wb_dst_reg    <= 5'd0;
            mem_wb_mem_to_reg <= 1'b0;
            mem_wb_reg_write  <= 1'b0;
        end else if (pass_through || misaligned_op) begin
            // A misaligned op is retired without memory data and without writeback.
            mem_wb_read_data  <= 32'd0;
            mem_wb_result     <= exe_mem_result;
            mem_wb_dst_reg    <= exe_mem_dst_reg;
            mem_wb_mem_to_reg <= mem_to_reg_in;
            mem_wb_reg_write  <= reg_write_in & ~misaligned_op;
        end else if (retire_access) begin
            mem_wb_read_data  <= (ack_done && is_load) ? dmem_rdata : 32'd0;
            mem_wb_result     <= exe_mem_result;
            mem_wb_dst_reg    <= exe_mem_dst_reg;
            mem_wb_mem_to_reg <= mem_to_reg_in;
            mem_wb_reg_write  <= reg_write_in & ack_done;
        end else begin
            mem_wb_mem_to_reg <= 1'b0;
            mem_wb_reg_write  <= 1'b0;
        end
    end

    // Error flags: one-cycle misalignment pulse and sticky timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_misaligned  <= 1'b0;
            mem_timeout_err <= 1'b0;
        end else begin
            mem_misaligned <= misaligned_op;
            if (timeout_hit) begin
                mem_timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Scoreboard bench for mem_stage_access_unit: a stimulus process issues
// instructions and pushes expected retirements, a memory responder answers
// requests, and a monitor checks each retirement.
module tb_mem_stage_access_unit;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] exe_mem_result;
    logic [31:0] exe_mem_store_data;
    logic [31:0] exe_mem_branch_address;
    logic [4:0]  exe_mem_dst_reg;
    logic        exe_mem_zero;
    logic        branch_equal_in;
    logic        branch_not_equal_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        mem_to_reg_in;
    logic        reg_write_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic [31:0] mem_wb_read_data;
    logic [31:0] mem_wb_result;
    logic [4:0]  mem_wb_dst_reg;
    logic        mem_wb_mem_to_reg;
    logic        mem_wb_reg_write;
    logic        mem_misaligned;
    logic        mem_timeout_err;

    mem_stage_access_unit #(.ACK_TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .exe_mem_result         (exe_mem_result),
        .exe_mem_store_data     (exe_mem_store_data),
        .exe_mem_branch_address (exe_mem_branch_address),
        .exe_mem_dst_reg        (exe_mem_dst_reg),
        .exe_mem_zero           (exe_mem_zero),
        .branch_equal_in        (branch_equal_in),
        .branch_not_equal_in    (branch_not_equal_in),
        .mem_read_in            (mem_read_in),
        .mem_write_in           (mem_write_in),
        .mem_to_reg_in          (mem_to_reg_in),
        .reg_write_in           (reg_write_in),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_wdata             (dmem_wdata),
        .dmem_ack               (dmem_ack),
        .dmem_rdata             (dmem_rdata),
        .mem_stall              (mem_stall),
        .pc_src                 (pc_src),
        .branch_target          (branch_target),
        .mem_wb_read_data       (mem_wb_read_data),
        .mem_wb_result          (mem_wb_result),
        .mem_wb_dst_reg         (mem_wb_dst_reg),
        .mem_wb_mem_to_reg      (mem_wb_mem_to_reg),
        .mem_wb_reg_write       (mem_wb_reg_write),
        .mem_misaligned         (mem_misaligned),
        .mem_timeout_err        (mem_timeout_err)
    );

    typedef struct {
        logic [31:0] result;
        logic [31:0] read_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] btarget;
        logic [4:0]  dst;
        logic        m2r;
        logic        rw;
        logic        we;
        logic        mis;
        logic        tmo;
        logic        pc;
        int          n_acc;
    } exp_t;

    exp_t        exp_q[$];
    int          dq_delay[$];
    logic [31:0] dq_rdata[$];

    int   checks;
    int   failures;
    logic mon_en;
    logic tmo_model;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic drive_nop();
        @(posedge clk);
        #1;
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        reg_write_in = 1'b0;
        mem_to_reg_in = 1'b0;
        branch_equal_in = 1'b0;
        branch_not_equal_in = 1'b0;
    endtask

    // Issue one instruction; d = ACCESS cycle on which memory acks (d > TMO never acks in time).
    task automatic issue(input logic [31:0] res, input logic [31:0] sdata, input logic [31:0] baddr,
                         input logic [4:0] dst, input logic zero, input logic beq, input logic bne,
                         input logic rd, input logic wr, input logic m2r, input logic rw,
                         input int d, input logic [31:0] rdata);
        exp_t e;
        logic memop;
        logic aligned;
        bit   done;
        memop   = rd | wr;
        aligned = (res % 4) == 0;
        e.result  = res;
        e.dst     = dst;
        e.m2r     = m2r;
        e.addr    = res;
        e.wdata   = sdata;
        e.we      = wr;
        e.btarget = baddr;
        e.pc      = (beq && zero) || (bne && !zero);
        e.mis     = memop && !aligned;
        e.read_data = 32'd0;
        e.n_acc   = 0;
        e.rw      = rw;
        if (memop && !aligned) begin
            e.rw = 1'b0;
        end else if (memop) begin
            if (d <= TMO) begin
                e.n_acc = d;
                if (rd && !wr) e.read_data = rdata;
            end else begin
                e.n_acc = TMO;
                e.rw = 1'b0;
                tmo_model = 1'b1;
            end
        end
        e.tmo = tmo_model;
        @(posedge clk);
        #1;
        exe_mem_result         = res;
        exe_mem_store_data     = sdata;
        exe_mem_branch_address = baddr;
        exe_mem_dst_reg        = dst;
        exe_mem_zero           = zero;
        branch_equal_in        = beq;
        branch_not_equal_in    = bne;
        mem_read_in            = rd;
        mem_write_in           = wr;
        mem_to_reg_in          = m2r;
        reg_write_in           = rw;
        exp_q.push_back(e);
        if (memop && aligned) begin
            dq_delay.push_back(d);
            dq_rdata.push_back(rdata);
        end
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!mem_stall) done = 1'b1;
        end
        if (!done) bound_fail("issue_wait");
    endtask

    task automatic drain();
        drive_nop();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) bound_fail("drain");
    endtask

    // Memory responder: acks on the chosen ACCESS cycle; random ignored acks when idle.
    initial begin
        int          cnt;
        int          d;
        logic [31:0] rdv;
        cnt = 0;
        d = 1000;
        rdv = 32'd0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0;
                dmem_ack = 1'b0;
            end else if (dmem_req) begin
                if (cnt == 0) begin
                    if (dq_delay.size() > 0) begin
                        d = dq_delay.pop_front();
                        rdv = dq_rdata.pop_front();
                    end else begin
                        d = 1000;
                    end
                end
                cnt++;
                dmem_ack = (cnt == d);
                dmem_rdata = (cnt == d) ? rdv : $urandom;
            end else begin
                cnt = 0;
                dmem_ack = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: accumulates stall/request cycles, then checks MEM/WB after the retiring edge.
    initial begin
        int          sc;
        int          rc;
        logic [31:0] ca;
        logic [31:0] cw;
        logic        cwe;
        exp_t        e;
        sc = 0;
        rc = 0;
        ca = 32'd0;
        cw = 32'd0;
        cwe = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en || exp_q.size() == 0) begin
                sc = 0;
                rc = 0;
            end else begin
                if (mem_stall) sc++;
                if (dmem_req) begin
                    if (rc == 0) begin
                        ca = dmem_addr;
                        cw = dmem_wdata;
                        cwe = dmem_we;
                    end
                    rc++;
                    check("bubble_reg_write", mem_wb_reg_write, 1'b0);
                end
                if (!mem_stall) begin
                    e = exp_q[0];
                    check("pc_src", pc_src, e.pc);
                    check("branch_target", branch_target, e.btarget);
                    check("stall_cycles", sc, e.n_acc);
                    check("req_cycles", rc, e.n_acc);
                    if (e.n_acc > 0) begin
                        check("dmem_addr", ca, e.addr);
                        check("dmem_wdata", cw, e.wdata);
                        check("dmem_we", cwe, e.we);
                    end
                    @(posedge clk);
                    #2;
                    e = exp_q.pop_front();
                    check("wb_result", mem_wb_result, e.result);
                    check("wb_dst", mem_wb_dst_reg, e.dst);
                    check("wb_mem_to_reg", mem_wb_mem_to_reg, e.m2r);
                    check("wb_reg_write", mem_wb_reg_write, e.rw);
                    check("wb_read_data", mem_wb_read_data, e.read_data);
                    check("misaligned", mem_misaligned, e.mis);
                    check("timeout_err", mem_timeout_err, e.tmo);
                    check("req_dropped", dmem_req, 1'b0);
                    sc = 0;
                    rc = 0;
                end
            end
        end
    end

    // Stimulus.
    initial begin
        bit seen;
        checks = 0;
        failures = 0;
        mon_en = 1'b0;
        tmo_model = 1'b0;
        rst_n = 1'b0;
        exe_mem_result = 32'd0;
        exe_mem_store_data = 32'd0;
        exe_mem_branch_address = 32'd0;
        exe_mem_dst_reg = 5'd0;
        exe_mem_zero = 1'b0;
        branch_equal_in = 1'b0;
        branch_not_equal_in = 1'b0;
        mem_read_in = 1'b0;
        mem_write_in = 1'b0;
        mem_to_reg_in = 1'b0;
        reg_write_in = 1'b0;
        #2;
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_wb_result", mem_wb_result, 32'd0);
        check("rst_wb_reg_write", mem_wb_reg_write, 1'b0);
        check("rst_timeout_err", mem_timeout_err, 1'b0);
        check("rst_misaligned", mem_misaligned, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed cases.
        issue(32'h10, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        issue(32'h100, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEADBEEF);
        issue(32'h204, 32'hCAFEF00D, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'h11111111);
        issue(32'h102, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h0);
        issue(32'h10C, 32'h55AA55AA, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 32'h77777777);
        issue(32'h108, 32'h0, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9, 32'h0);
        issue(32'h20, 32'h0, 32'h400, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 32'h0);
        issue(32'h24, 32'h0, 32'h500, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        issue(32'h28, 32'h0, 32'h600, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        drain();
        check("tmo_sticky_pre_rst", mem_timeout_err, 1'b1);

        // Reset asserted in the middle of an access.
        mon_en = 1'b0;
        dq_delay.push_back(100);
        dq_rdata.push_back(32'h0);
        @(posedge clk);
        #1;
        exe_mem_result = 32'h300;
        mem_read_in = 1'b1;
        reg_write_in = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5 && !seen; k++) begin
            @(negedge clk);
            if (dmem_req) seen = 1'b1;
        end
        if (!seen) bound_fail("mid_rst_req_wait");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dmem_req", dmem_req, 1'b0);
        check("mid_rst_timeout_err", mem_timeout_err, 1'b0);
        mem_read_in = 1'b0;
        reg_write_in = 1'b0;
        #1;
        check("mid_rst_idle_stall", mem_stall, 1'b0);
        dq_delay.delete();
        dq_rdata.delete();
        tmo_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        issue(32'h10, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 32'h0);

        // Randomized instructions.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            int          kind;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            kind = $urandom_range(0, 3);
            issue(a, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                  1'($urandom), 1'($urandom), $urandom_range(1, 6), $urandom);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
